// File: rtl/async_fifo_gray_pkg.sv
`default_nettype none
// ============================================================================
//  Package : fifo_pkg
//  Purpose : Shared helpers for the Gray-pointer dual-clock FIFO.
//            Pointer conversion functions work on the widest legal pointer.
//            Callers zero-extend narrower pointers on the way in and truncate
//            on the way out. Leading zero bits do not change either result.
//  Contents: c_max_addr_width, c_ptr_max_w, ptr_max_t, level_width(),
//            bin2gray(), gray2bin()
//  Revision: 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Largest supported log2(depth); pointers and levels carry one extra wrap bit.
    localparam int c_max_addr_width = 8;
    localparam int c_ptr_max_w      = c_max_addr_width + 1;

    typedef logic [c_ptr_max_w-1:0] ptr_max_t;

    // Width of a pointer or level count for a given log2(depth).
    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of every Gray bit at or above it.
    function automatic ptr_max_t gray2bin(input ptr_max_t gray);
        ptr_max_t bin;
        bin[c_ptr_max_w-1] = gray[c_ptr_max_w-1];
        for (int i = c_ptr_max_w - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/async_fifo_gray_sync2.sv
`default_nettype none
// ============================================================================
//  Module  : sync2
//  Purpose : Two-flop synchroniser for a Gray-coded pointer. The reset is
//            synchronous and active low, and it is sampled in the
//            destination clock domain.
//  Ports   : clk_i    destination clock
//            rst_n_i  synchronous active-low reset
//            d_i      W-bit value from the source domain
//            q_o      W-bit value synchronised to clk_i
//  Revision: 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/async_fifo_gray.sv
`default_nettype none
// ============================================================================
//  Module  : async_fifo_gray
//  Purpose : Dual-clock FIFO with first-word-fall-through reads.
//            The write side runs on clkin (host bus) and the read side runs
//            on clkout (SDRAM controller). Only Gray-coded pointers cross
//            between the two domains.
//  Ports   : clkout       read-side clock
//            rst_n        synchronous active-low reset, sampled on both clocks
//            clkin        write-side clock
//            datain       write data, stored when wr && !full
//            wr           write strobe (clkin)
//            full         no free slot; writes are dropped while high
//            almost_full  wr_level >= DEPTH - AF_MARGIN
//            wr_level     occupancy seen from clkin (may over-report)
//            dataout      head word, valid while empty_n is high
//            rd           pop strobe (clkout)
//            empty_n      at least one word readable
//            rd_level     occupancy seen from clkout (may under-report)
//  Revision: 1.0 - initial release
// ============================================================================
module async_fifo_gray
    import fifo_pkg::*;
#(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clkout,
    input  logic                  rst_n,
    input  logic                  clkin,
    input  logic [BUS_WIDTH-1:0]  datain,
    input  logic                  wr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic [BUS_WIDTH-1:0]  dataout,
    input  logic                  rd,
    output logic                  empty_n,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam int c_depth = 2 ** ADDR_WIDTH;
    localparam int c_pw    = level_width(ADDR_WIDTH);

    typedef logic [c_pw-1:0] ptr_t;

    localparam ptr_t c_af_level = ptr_t'(c_depth - AF_MARGIN);

    function automatic ptr_t to_gray(input ptr_t bin);
        return ptr_t'(bin2gray(ptr_max_t'(bin)));
    endfunction

    function automatic ptr_t to_bin(input ptr_t gray);
        return ptr_t'(gray2bin(ptr_max_t'(gray)));
    endfunction

    // ------------------------------------------------------------------
    // Storage: distributed RAM without reset, written on clkin, read
    // combinationally on the read side.
    // ------------------------------------------------------------------
    logic [BUS_WIDTH-1:0] mem_q [c_depth];

    // ------------------------------------------------------------------
    // Write domain (clkin)
    // ------------------------------------------------------------------
    ptr_t wbin_q,  wbin_d;
    ptr_t wgray_q, wgray_d;
    ptr_t wr_level_q, wr_level_d;
    logic full_q, full_d;
    logic almost_full_q, almost_full_d;
    logic w_wr_en;
    ptr_t w_wq2_rgray;

    // Writes are also ignored while reset is held, so nothing is stored
    // into the RAM during reset.
    assign w_wr_en = wr && !full_q && rst_n;

    always_comb begin
        wbin_d        = wbin_q + ptr_t'(w_wr_en);
        wgray_d       = to_gray(wbin_d);
        // The FIFO is full when the write pointer is one lap ahead of the
        // read pointer. In Gray code this means the top two bits differ and
        // all lower bits are equal.
        full_d        = (wgray_d == {~w_wq2_rgray[c_pw-1:c_pw-2], w_wq2_rgray[c_pw-3:0]});
        wr_level_d    = wbin_d - to_bin(w_wq2_rgray);
        almost_full_d = (wr_level_d >= c_af_level);
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            wbin_q        <= '0;
            wgray_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            wr_level_q    <= '0;
        end else begin
            wbin_q        <= wbin_d;
            wgray_q       <= wgray_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            wr_level_q    <= wr_level_d;
        end
    end

    always_ff @(posedge clkin) begin
        if (w_wr_en) begin
            mem_q[wbin_q[ADDR_WIDTH-1:0]] <= datain;
        end
    end

    // ------------------------------------------------------------------
    // Read domain (clkout)
    // ------------------------------------------------------------------
    ptr_t rbin_q,  rbin_d;
    ptr_t rgray_q, rgray_d;
    ptr_t rd_level_q, rd_level_d;
    logic empty_n_q, empty_n_d;
    logic w_rd_en;
    ptr_t w_rq2_wgray;

    assign w_rd_en = rd && empty_n_q;

    always_comb begin
        rbin_d     = rbin_q + ptr_t'(w_rd_en);
        rgray_d    = to_gray(rbin_d);
        empty_n_d  = (rgray_d != w_rq2_wgray);
        rd_level_d = to_bin(w_rq2_wgray) - rbin_d;
    end

    always_ff @(posedge clkout) begin
        if (!rst_n) begin
            rbin_q     <= '0;
            rgray_q    <= '0;
            empty_n_q  <= 1'b0;
            rd_level_q <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            empty_n_q  <= empty_n_d;
            rd_level_q <= rd_level_d;
        end
    end

    // ------------------------------------------------------------------
    // Pointer crossings
    // ------------------------------------------------------------------
    sync2 #(.W(c_pw)) u_sync_rgray (
        .clk_i   (clkin),
        .rst_n_i (rst_n),
        .d_i     (rgray_q),
        .q_o     (w_wq2_rgray)
    );

    sync2 #(.W(c_pw)) u_sync_wgray (
        .clk_i   (clkout),
        .rst_n_i (rst_n),
        .d_i     (wgray_q),
        .q_o     (w_rq2_wgray)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign wr_level    = wr_level_q;
    assign empty_n     = empty_n_q;
    assign rd_level    = rd_level_q;
    assign dataout     = mem_q[rbin_q[ADDR_WIDTH-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_gray.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_async_fifo_gray
//  Purpose : Self-checking bench for async_fifo_gray (16 bits wide, 8 deep,
//            AF_MARGIN 2). A queue holds every accepted write in order, and
//            each pop is compared against the front of that queue.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_async_fifo_gray;

    localparam int BW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clkin   = 1'b0;
    logic          clkout  = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr      = 1'b0;
    logic          rd      = 1'b0;
    logic [BW-1:0] datain  = '0;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wr_level;
    logic [BW-1:0] dataout;
    logic          empty_n;
    logic [AW:0]   rd_level;

    int in_half  = 5;
    int out_half = 20;

    int checks = 0;
    int errors = 0;
    int total_popped = 0;

    logic [BW-1:0] sb [$];

    always #(in_half)  clkin  = ~clkin;
    always #(out_half) clkout = ~clkout;

    async_fifo_gray #(
        .BUS_WIDTH  (BW),
        .ADDR_WIDTH (AW),
        .AF_MARGIN  (2)
    ) dut (
        .clkout      (clkout),
        .rst_n       (rst_n),
        .clkin       (clkin),
        .datain      (datain),
        .wr          (wr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .dataout     (dataout),
        .rd          (rd),
        .empty_n     (empty_n),
        .rd_level    (rd_level)
    );

    task automatic in_step();
        @(posedge clkin);
        #1;
    endtask

    task automatic out_step();
        @(posedge clkout);
        #1;
    endtask

    // Hold reset for four cycles of each clock, which covers at least three
    // cycles of the slower one.
    task automatic do_reset();
        rst_n = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        repeat (4) @(posedge clkout);
        repeat (4) @(posedge clkin);
        #1;
        rst_n = 1'b1;
        sb.delete();
        out_step();
        in_step();
    endtask

    // Write one word during the next clkin cycle. The queue records the word
    // only if the DUT will accept it.
    task automatic push_write(input logic [BW-1:0] d);
        wr     = 1'b1;
        datain = d;
        if (full === 1'b0) sb.push_back(d);
        in_step();
        wr = 1'b0;
    endtask

    task automatic wait_empty_n(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            out_step();
            if (empty_n === 1'b1) ok = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        in_half = 5; out_half = 20;
        do_reset();
        checks++; if (full !== 1'b0)        begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
        checks++; if (wr_level !== 4'd0)    begin errors++; $display("FAIL reset_wr_level got %0d exp 0", wr_level); end
        checks++; if (empty_n !== 1'b0)     begin errors++; $display("FAIL reset_empty_n got %b exp 0", empty_n); end
        checks++; if (rd_level !== 4'd0)    begin errors++; $display("FAIL reset_rd_level got %0d exp 0", rd_level); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        bit ok;
        logic [BW-1:0] exp;
        in_half = 5; out_half = 20;
        do_reset();
        push_write(16'h1111);
        wait_empty_n(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_latency empty_n got %b exp 1 within 3 edges", empty_n); end
        exp = sb.pop_front();
        checks++; if (dataout !== exp) begin errors++; $display("FAIL single_data got %h exp %h", dataout, exp); end
        rd = 1'b1;
        out_step();
        rd = 1'b0;
        checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL single_pop_empty got %b exp 0", empty_n); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fill();
        bit ok;
        logic [BW-1:0] exp;
        in_half = 5; out_half = 20;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push_write(BW'(i));
            checks++; if (wr_level !== 4'(i + 1)) begin errors++; $display("FAIL fill_wr_level[%0d] got %0d exp %0d", i, wr_level, i + 1); end
            checks++; if (almost_full !== ((i + 1) >= 6)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i + 1) >= 6); end
            checks++; if (full !== (i == DEPTH - 1)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, i == DEPTH - 1); end
        end
        push_write(16'hFFFF);
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL fill_drop_full got %b exp 1", full); end
        checks++; if (wr_level !== 4'd8) begin errors++; $display("FAIL fill_drop_level got %0d exp 8", wr_level); end
        wait_empty_n(4, ok);
        repeat (3) out_step();
        checks++; if (rd_level !== 4'd8) begin errors++; $display("FAIL fill_rd_level got %0d exp 8", rd_level); end
        for (int i = 0; i < DEPTH; i++) begin
            exp = sb.pop_front();
            checks++; if (empty_n !== 1'b1 || dataout !== exp) begin errors++; $display("FAIL fill_read[%0d] got %h (empty_n %b) exp %h", i, dataout, empty_n, exp); end
            rd = 1'b1;
            out_step();
        end
        rd = 1'b0;
        checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL fill_drained got %b exp 0", empty_n); end
        ok = 1'b0;
        for (int i = 0; i < 3 && !ok; i++) begin
            in_step();
            if (full === 1'b0) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL fill_full_release got %b exp 0", full); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stream(input int n, input int ih, input int oh,
                               input int wduty, input int rduty);
        int sent = 0;
        int received = 0;
        in_half = ih; out_half = oh;
        do_reset();
        fork
            begin : writer
                int guard = 0;
                while (sent < n && guard < 20000) begin
                    if ($urandom_range(0, 99) < wduty) begin
                        wr     = 1'b1;
                        datain = 16'($urandom);
                        if (full === 1'b0) begin
                            sb.push_back(datain);
                            sent++;
                        end
                    end else begin
                        wr = 1'b0;
                    end
                    in_step();
                    guard++;
                end
                wr = 1'b0;
            end
            begin : reader
                int guard = 0;
                logic [BW-1:0] exp;
                out_step();
                while (received < n && guard < 20000) begin
                    if (empty_n === 1'b1 && $urandom_range(0, 99) < rduty) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL stream_extra got %h exp no word", dataout);
                        end else begin
                            exp = sb.pop_front();
                            if (dataout !== exp) begin
                                errors++;
                                $display("FAIL stream_data[%0d] got %h exp %h", received, dataout, exp);
                            end
                        end
                        rd = 1'b1;
                        received++;
                    end else begin
                        rd = 1'b0;
                    end
                    out_step();
                    guard++;
                end
                rd = 1'b0;
            end
        join
        total_popped += received;
        checks++; if (received != n) begin errors++; $display("FAIL stream_count got %0d exp %0d", received, n); end
        repeat (4) out_step();
        checks++; if (empty_n !== 1'b0 || sb.size() != 0) begin errors++; $display("FAIL stream_leftover empty_n %b queue %0d exp 0 0", empty_n, sb.size()); end
    endtask

    // ------------------------------------------------------------------
    // Occupancy 7 with paired write+pop on one shared edge. The write side
    // may briefly see 8 words until the pop crosses over; the read side must
    // never see the FIFO as empty.
    task automatic test_concurrent();
        logic [BW-1:0] exp;
        logic [BW-1:0] nw;
        in_half = 10; out_half = 10;
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) push_write(16'h7000 + BW'(i));
        repeat (6) in_step();
        checks++; if (wr_level !== 4'd7 || rd_level !== 4'd7) begin errors++; $display("FAIL conc_start levels got %0d/%0d exp 7/7", wr_level, rd_level); end
        for (int k = 0; k < 10; k++) begin
            exp = sb.pop_front();
            checks++; if (dataout !== exp) begin errors++; $display("FAIL conc_data[%0d] got %h exp %h", k, dataout, exp); end
            nw     = 16'($urandom);
            wr     = 1'b1;
            datain = nw;
            if (full === 1'b0) sb.push_back(nw);
            rd = 1'b1;
            in_step();
            wr = 1'b0;
            rd = 1'b0;
            for (int c = 0; c < 4; c++) begin
                checks++; if (empty_n !== 1'b1) begin errors++; $display("FAIL conc_empty[%0d] got %b exp 1", k, empty_n); end
                in_step();
            end
            checks++; if (full !== 1'b0 || wr_level !== 4'd7) begin errors++; $display("FAIL conc_settle[%0d] full %b level %0d exp 0 7", k, full, wr_level); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        bit ok;
        logic [BW-1:0] exp;
        in_half = 5; out_half = 20;
        do_reset();
        for (int i = 0; i < 5; i++) push_write(16'h5000 + BW'(i));
        repeat (4) out_step();
        checks++; if (rd_level !== 4'd5) begin errors++; $display("FAIL mid_pre_level got %0d exp 5", rd_level); end
        rst_n  = 1'b0;
        wr     = 1'b1;
        datain = 16'h5555;
        repeat (3) @(posedge clkout);
        #1;
        wr    = 1'b0;
        rst_n = 1'b1;
        sb.delete();
        repeat (2) out_step();
        checks++; if (empty_n !== 1'b0)  begin errors++; $display("FAIL mid_empty_n got %b exp 0", empty_n); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL mid_full got %b/%b exp 0/0", full, almost_full); end
        checks++; if (wr_level !== 4'd0 || rd_level !== 4'd0) begin errors++; $display("FAIL mid_levels got %0d/%0d exp 0/0", wr_level, rd_level); end
        push_write(16'hABCD);
        wait_empty_n(4, ok);
        exp = sb.pop_front();
        checks++; if (!ok || dataout !== exp) begin errors++; $display("FAIL mid_readback got %h (empty_n %b) exp %h", dataout, empty_n, exp); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_idle_ops();
        bit ok;
        logic [BW-1:0] exp;
        in_half = 5; out_half = 20;
        do_reset();
        rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            out_step();
            checks++; if (empty_n !== 1'b0 || rd_level !== 4'd0 || wr_level !== 4'd0) begin errors++; $display("FAIL idle_rd[%0d] empty_n %b levels %0d/%0d exp 0 0/0", i, empty_n, rd_level, wr_level); end
        end
        rd = 1'b0;
        push_write(16'h0A0A);
        wait_empty_n(4, ok);
        repeat (2) out_step();
        checks++; if (!ok || dataout !== 16'h0A0A || rd_level !== 4'd1) begin errors++; $display("FAIL idle_rd_ptr got %h level %0d exp 0a0a 1", dataout, rd_level); end
        for (int i = 1; i < DEPTH; i++) push_write(16'h0100 + BW'(i));
        wr     = 1'b1;
        datain = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            in_step();
            checks++; if (full !== 1'b1 || wr_level !== 4'd8) begin errors++; $display("FAIL idle_wr[%0d] full %b level %0d exp 1 8", i, full, wr_level); end
        end
        wr = 1'b0;
        repeat (3) out_step();
        for (int i = 0; i < DEPTH; i++) begin
            exp = sb.pop_front();
            checks++; if (dataout !== exp) begin errors++; $display("FAIL idle_drain[%0d] got %h exp %h", i, dataout, exp); end
            rd = 1'b1;
            out_step();
        end
        rd = 1'b0;
        checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL idle_drained got %b exp 0", empty_n); end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream(400, 5, 25, 70, 80);
        test_stream(400, 10, 10, 50, 50);
        test_stream(400, 25, 5, 80, 60);
        checks++;
        if (total_popped / DEPTH < 100) begin
            errors++;
            $display("FAIL stream_wraps got %0d exp >= 100", total_popped / DEPTH);
        end
        test_concurrent();
        test_reset_mid();
        test_idle_ops();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
